// File: rtl/trafficlight_pkg.sv
// Shared phase encodings and lamp patterns for the traffic light controller and its monitor.
// Pure declarations: no state, no latency, no flow control.
package trafficlight_pkg;

    typedef enum logic [2:0] {
        PH_START = 3'b111,
        PH_NS    = 3'b011,
        PH_NY    = 3'b010,
        PH_EW    = 3'b000,
        PH_EY    = 3'b001,
        PH_BAD   = 3'b100
    } phase_e;

    // Lamp vector order is {red, yellow, green}
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Only successor accepted from a phase; PH_BAD means no legal successor.
    function automatic phase_e legal_next(input phase_e p);
        phase_e n;
        case (p)
            PH_START: n = PH_NS;
            PH_NS:    n = PH_NY;
            PH_NY:    n = PH_EW;
            PH_EW:    n = PH_EY;
            PH_EY:    n = PH_NS;
            default:  n = PH_BAD;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/trafficlight_monitor_lamp_decode.sv
// Combinational six-lamp to phase decoder (module tl_lamp_decode); zero latency, no flow control.
// Any pattern outside the five legal ones decodes to PH_BAD.
module tl_lamp_decode
    import trafficlight_pkg::*;
(
    input  logic [2:0] lamp_a_i,
    input  logic [2:0] lamp_b_i,
    output phase_e     phase_o
);

    always_comb begin
        phase_o = PH_BAD;
        if (lamp_b_i == LAMP_R) begin
            case (lamp_a_i)
                LAMP_R:  phase_o = PH_START;
                LAMP_G:  phase_o = PH_NS;
                LAMP_Y:  phase_o = PH_NY;
                default: phase_o = PH_BAD;
            endcase
        end else if (lamp_a_i == LAMP_R) begin
            case (lamp_b_i)
                LAMP_G:  phase_o = PH_EW;
                LAMP_Y:  phase_o = PH_EY;
                default: phase_o = PH_BAD;
            endcase
        end
    end

endmodule

// File: rtl/trafficlight_monitor.sv
// Traffic light observer: checks lamp legality, phase order and phase duration, sticky error flags.
// Lamp change to o_phase/flags is 2 cycles; passive observer, never stalls anything.
module trafficlight_monitor
    import trafficlight_pkg::*;
#(
    parameter int NS_TICKS = 90,
    parameter int EW_TICKS = 60,
    parameter int Y_TICKS  = 30,
    parameter int TOL      = 2,
    parameter int T_WIDTH  = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_clr,
    input  logic               i_reda,
    input  logic               i_yellowa,
    input  logic               i_greena,
    input  logic               i_redb,
    input  logic               i_yellowb,
    input  logic               i_greenb,
    output logic [2:0]         o_phase,
    output logic               o_phase_done,
    output logic [T_WIDTH-1:0] o_last_len,
    output logic               o_err_lamp,
    output logic               o_err_seq,
    output logic               o_err_time,
    output logic [15:0]        o_cycles
);

    localparam logic [T_WIDTH-1:0] NS_LO = T_WIDTH'(NS_TICKS - TOL);
    localparam logic [T_WIDTH-1:0] NS_HI = T_WIDTH'(NS_TICKS + TOL);
    localparam logic [T_WIDTH-1:0] NS_TO = T_WIDTH'(NS_TICKS + TOL + 1);
    localparam logic [T_WIDTH-1:0] EW_LO = T_WIDTH'(EW_TICKS - TOL);
    localparam logic [T_WIDTH-1:0] EW_HI = T_WIDTH'(EW_TICKS + TOL);
    localparam logic [T_WIDTH-1:0] EW_TO = T_WIDTH'(EW_TICKS + TOL + 1);
    localparam logic [T_WIDTH-1:0] Y_LO  = T_WIDTH'(Y_TICKS - TOL);
    localparam logic [T_WIDTH-1:0] Y_HI  = T_WIDTH'(Y_TICKS + TOL);
    localparam logic [T_WIDTH-1:0] Y_TO  = T_WIDTH'(Y_TICKS + TOL + 1);

    // Stage 1: raw lamp sample
    logic [2:0] lamp_a_q, lamp_b_q;
    logic       s1_vld_q;
    phase_e     dec_phase;

    // Stage 2: phase tracking and checking
    phase_e             phase_q, phase_d;
    logic               checked_q, checked_d;
    logic [T_WIDTH-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [T_WIDTH-1:0] last_len_q, last_len_d;
    logic               err_lamp_q, err_lamp_d;
    logic               err_seq_q, err_seq_d;
    logic               err_time_q, err_time_d;
    logic [15:0]        cycles_q, cycles_d;

    phase_e             obs_phase;
    logic [T_WIDTH-1:0] len_lo, len_hi, len_to;
    logic               set_lamp, set_seq, set_time;

    tl_lamp_decode u_decode (
        .lamp_a_i (lamp_a_q),
        .lamp_b_i (lamp_b_q),
        .phase_o  (dec_phase)
    );

    always_comb begin
        len_lo = Y_LO;
        len_hi = Y_HI;
        len_to = Y_TO;
        case (phase_q)
            PH_NS: begin
                len_lo = NS_LO;
                len_hi = NS_HI;
                len_to = NS_TO;
            end
            PH_EW: begin
                len_lo = EW_LO;
                len_hi = EW_HI;
                len_to = EW_TO;
            end
            default: ;
        endcase
    end

    always_comb begin
        phase_d    = phase_q;
        checked_d  = checked_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        last_len_d = last_len_q;
        cycles_d   = cycles_q;
        set_lamp   = 1'b0;
        set_seq    = 1'b0;
        set_time   = 1'b0;

        // Stage 1 still holds reset zeros on the first cycle out of reset; do not decode them as BAD.
        obs_phase = s1_vld_q ? dec_phase : phase_q;

        if (obs_phase != phase_q) begin
            phase_d = obs_phase;
            cnt_d   = '0;
            if (checked_q) begin
                done_d     = 1'b1;
                last_len_d = cnt_q;
                if ((cnt_q < len_lo) || (cnt_q > len_hi)) begin
                    set_time = 1'b1;
                end
            end
            if (obs_phase == PH_BAD) begin
                set_lamp  = 1'b1;
                checked_d = 1'b0;
            end else if (phase_q == PH_BAD) begin
                checked_d = 1'b0;
            end else if (obs_phase == legal_next(phase_q)) begin
                checked_d = 1'b1;
                if ((phase_q == PH_EY) && (cycles_q != 16'hFFFF)) begin
                    cycles_d = cycles_q + 16'd1;
                end
            end else begin
                set_seq   = 1'b1;
                checked_d = 1'b0;
            end
        end else if (i_tick && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
            if (checked_q && (cnt_d == len_to)) begin
                set_time = 1'b1;
            end
        end

        // A fresh error in the clear cycle must survive the clear.
        err_lamp_d = set_lamp | (err_lamp_q & ~i_clr);
        err_seq_d  = set_seq  | (err_seq_q  & ~i_clr);
        err_time_d = set_time | (err_time_q & ~i_clr);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lamp_a_q   <= '0;
            lamp_b_q   <= '0;
            s1_vld_q   <= 1'b0;
            phase_q    <= PH_START;
            checked_q  <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            last_len_q <= '0;
            err_lamp_q <= 1'b0;
            err_seq_q  <= 1'b0;
            err_time_q <= 1'b0;
            cycles_q   <= '0;
        end else begin
            lamp_a_q   <= {i_reda, i_yellowa, i_greena};
            lamp_b_q   <= {i_redb, i_yellowb, i_greenb};
            s1_vld_q   <= 1'b1;
            phase_q    <= phase_d;
            checked_q  <= checked_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            last_len_q <= last_len_d;
            err_lamp_q <= err_lamp_d;
            err_seq_q  <= err_seq_d;
            err_time_q <= err_time_d;
            cycles_q   <= cycles_d;
        end
    end

    assign o_phase      = phase_q;
    assign o_phase_done = done_q;
    assign o_last_len   = last_len_q;
    assign o_err_lamp   = err_lamp_q;
    assign o_err_seq    = err_seq_q;
    assign o_err_time   = err_time_q;
    assign o_cycles     = cycles_q;

endmodule

// File: tb/tb_trafficlight_monitor.sv
// Directed bench for trafficlight_monitor; i_tick is high every cycle, so holding lamps
// for L+1 cycles yields a phase length of L ticks (the tick in the change cycle is dropped).
module tb_trafficlight_monitor;

    logic        clk = 1'b0;
    logic        rst, tick, clr;
    logic [2:0]  la, lb;
    logic [2:0]  o_phase;
    logic        o_phase_done;
    logic [11:0] o_last_len;
    logic        o_err_lamp, o_err_seq, o_err_time;
    logic [15:0] o_cycles;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
    localparam logic [2:0] P_START = 3'b111, P_NS = 3'b011, P_NY = 3'b010;
    localparam logic [2:0] P_EW = 3'b000, P_EY = 3'b001, P_BAD = 3'b100;

    trafficlight_monitor dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tick       (tick),
        .i_clr        (clr),
        .i_reda       (la[2]),
        .i_yellowa    (la[1]),
        .i_greena     (la[0]),
        .i_redb       (lb[2]),
        .i_yellowb    (lb[1]),
        .i_greenb     (lb[0]),
        .o_phase      (o_phase),
        .o_phase_done (o_phase_done),
        .o_last_len   (o_last_len),
        .o_err_lamp   (o_err_lamp),
        .o_err_seq    (o_err_seq),
        .o_err_time   (o_err_time),
        .o_cycles     (o_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive new lamps, then check the phase they produce two edges later.
    task automatic enter(input string tag, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] ph, input logic dn, input int len);
        la = a;
        lb = b;
        waitc(2);
        chk({tag, "_phase"}, 32'(o_phase), 32'(ph));
        chk({tag, "_done"}, 32'(o_phase_done), 32'(dn));
        if (dn) chk({tag, "_len"}, 32'(o_last_len), 32'(len));
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        waitc(1);
        clr = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b1;
        clr  = 1'b0;
        la   = R;
        lb   = R;
        waitc(2);
        chk("rst_phase", 32'(o_phase), 32'(P_START));
        chk("rst_done", 32'(o_phase_done), 0);
        chk("rst_len", 32'(o_last_len), 0);
        chk("rst_errs", 32'({o_err_lamp, o_err_seq, o_err_time}), 0);
        chk("rst_cycles", 32'(o_cycles), 0);
        rst = 1'b0;
        waitc(2);
        chk("start_phase", 32'(o_phase), 32'(P_START));
        chk("start_lamp", 32'(o_err_lamp), 0);

        // Two nominal cycles
        enter("ns1", G, R, P_NS, 1'b0, 0);  waitc(89);
        enter("ny1", Y, R, P_NY, 1'b1, 90); waitc(29);
        enter("ew1", R, G, P_EW, 1'b1, 30); waitc(59);
        enter("ey1", R, Y, P_EY, 1'b1, 60); waitc(29);
        enter("ns2", G, R, P_NS, 1'b1, 30);
        chk("cycles1", 32'(o_cycles), 1);
        waitc(89);
        enter("ny2", Y, R, P_NY, 1'b1, 90); waitc(29);
        enter("ew2", R, G, P_EW, 1'b1, 30); waitc(59);
        enter("ey2", R, Y, P_EY, 1'b1, 60); waitc(29);
        enter("ns3", G, R, P_NS, 1'b1, 30);
        chk("cycles2", 32'(o_cycles), 2);
        chk("nominal_errs", 32'({o_err_lamp, o_err_seq, o_err_time}), 0);

        // NS stuck: timeout fires when the count reaches 93
        waitc(92);
        chk("to_before", 32'(o_err_time), 0);
        waitc(1);
        chk("to_at93", 32'(o_err_time), 1);
        chk("to_phase", 32'(o_phase), 32'(P_NS));
        enter("ny_long", Y, R, P_NY, 1'b1, 94);
        pulse_clr();
        chk("clr_time", 32'(o_err_time), 0);
        waitc(28);
        enter("ew3", R, G, P_EW, 1'b1, 30); waitc(59);
        enter("ey3", R, Y, P_EY, 1'b1, 60); waitc(29);
        enter("ns4", G, R, P_NS, 1'b1, 30); waitc(87);
        enter("ny88", Y, R, P_NY, 1'b1, 88);
        chk("ns88_ok", 32'(o_err_time), 0);

        // EW short
        waitc(29);
        enter("ew4", R, G, P_EW, 1'b1, 30); waitc(56);
        enter("ey57", R, Y, P_EY, 1'b1, 57);
        chk("ew57_err", 32'(o_err_time), 1);
        pulse_clr();
        waitc(28);
        enter("ns5", G, R, P_NS, 1'b1, 30);
        chk("cycles4", 32'(o_cycles), 4);
        waitc(89);

        // Both greens for a single cycle, then resync into NY
        la = G; lb = G;
        waitc(1);
        la = Y; lb = R;
        waitc(1);
        chk("bad_phase", 32'(o_phase), 32'(P_BAD));
        chk("bad_lamp", 32'(o_err_lamp), 1);
        chk("bad_nsdone", 32'(o_phase_done), 1);
        chk("bad_nslen", 32'(o_last_len), 90);
        chk("bad_seq", 32'(o_err_seq), 0);
        waitc(1);
        chk("resync_phase", 32'(o_phase), 32'(P_NY));
        chk("resync_seq", 32'(o_err_seq), 0);
        chk("resync_done", 32'(o_phase_done), 0);
        waitc(4);
        enter("ew_resync", R, G, P_EW, 1'b0, 0);
        chk("resync_time", 32'(o_err_time), 0);
        pulse_clr();
        chk("clr_lamp", 32'(o_err_lamp), 0);

        // NS jumping straight to EW
        waitc(58);
        enter("ey5", R, Y, P_EY, 1'b1, 60); waitc(29);
        enter("ns6", G, R, P_NS, 1'b1, 30);
        chk("cycles5", 32'(o_cycles), 5);
        waitc(89);
        enter("ns_to_ew", R, G, P_EW, 1'b1, 90);
        chk("seq_set", 32'(o_err_seq), 1);
        chk("seq_time", 32'(o_err_time), 0);
        pulse_clr();
        chk("seq_clr", 32'(o_err_seq), 0);
        la = G; lb = R;
        waitc(1);
        clr = 1'b1;
        waitc(1);
        clr = 1'b0;
        chk("seq_clr_wins", 32'(o_err_seq), 1);
        chk("ew_ns_phase", 32'(o_phase), 32'(P_NS));
        chk("ew_ns_done", 32'(o_phase_done), 0);
        chk("cycles_hold", 32'(o_cycles), 5);

        // Reset in the middle of EW, resume at NS
        enter("ny_short", Y, R, P_NY, 1'b0, 0); waitc(4);
        enter("ew_after", R, G, P_EW, 1'b1, 5);
        chk("ny5_err", 32'(o_err_time), 1);
        waitc(10);
        rst = 1'b1;
        waitc(1);
        rst = 1'b0;
        la = G; lb = R;
        chk("mid_rst_phase", 32'(o_phase), 32'(P_START));
        chk("mid_rst_errs", 32'({o_err_lamp, o_err_seq, o_err_time}), 0);
        chk("mid_rst_cycles", 32'(o_cycles), 0);
        chk("mid_rst_len", 32'(o_last_len), 0);
        waitc(2);
        chk("resume_phase", 32'(o_phase), 32'(P_NS));
        chk("resume_errs", 32'({o_err_lamp, o_err_seq, o_err_time}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
